// File: rtl/shift_capture.sv
// shift_capture: assembles WIDTH serial bits (MSB first) into a word and holds it until it is acknowledged.
module shift_capture #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iClr,
  input  logic             iStart,
  input  logic             iSER,
  input  logic             iAck,
  output logic             oShift,
  output logic [WIDTH-1:0] oData,
  output logic             oValid,
  output logic             oBusy,
  output logic             oOverrun
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh, r_data, w_word;
  logic             r_valid, r_ovr, w_last, w_enter;
  assign w_last  = r_cnt == CW'(WIDTH - 1);
  assign w_word  = {r_sh[WIDTH-2:0], iSER};
  assign w_enter = w_next == CAPTURE && r_state != CAPTURE;
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE    ? (iStart ? CAPTURE : IDLE) :
             r_state == CAPTURE ? (w_last ? HOLD : CAPTURE) :
             r_state == HOLD    ? (iAck ? (iStart ? CAPTURE : IDLE) : HOLD) : IDLE;
  end
  always_ff @(negedge iClk) begin
    if (iClr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_enter) r_cnt <= '0;
      else if (r_state == CAPTURE && !w_last) r_cnt <= r_cnt + CW'(1);
      if (r_state == CAPTURE) r_sh <= w_word;
      if (r_state == CAPTURE && w_last) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (r_state == HOLD && iAck) r_valid <= 1'b0;
      // a start that cannot be honoured because the word is still unread
      if (r_state == HOLD && iStart && !iAck) r_ovr <= 1'b1;
    end
  end
  assign oShift   = r_state == CAPTURE;
  assign oBusy    = r_state == CAPTURE;
  assign oData    = r_data;
  assign oValid   = r_valid;
  assign oOverrun = r_ovr;
endmodule
